// File: rtl/refclk_sequencer.sv
// Powers the SERDES refclk input buffer, qualifies refclk frequency over clk-timed windows and supervises lock.
// Define REFCLK_SEQ_AUTO_RETRY_EN to build the timed auto-retry out of FAULT.
module refclk_sequencer #(
  parameter int PWRUP_CYCLES  = 1024,
  parameter int WINDOW_CYCLES = 4096,
  parameter int CNT_W         = 16,
  parameter int CNT_MIN       = 900,
  parameter int CNT_MAX       = 1100,
  parameter int GOOD_WINDOWS  = 4,
  parameter int BAD_WINDOWS   = 2
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
  ,
  parameter int RETRY_CYCLES  = 65536
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic             refclk_tgl,
  output logic             refclk_pwdnb,
  output logic             refclk_ok,
  output logic             fault,
  output logic [CNT_W-1:0] meas_count,
  output logic [2:0]       state_o
);

  localparam int PW_W  = (PWRUP_CYCLES > 1) ? $clog2(PWRUP_CYCLES) : 1;
  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int GD_W  = $clog2(GOOD_WINDOWS + 1);
  localparam int BD_W  = $clog2(BAD_WINDOWS + 1);

  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PWRUP_CYCLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GD_W-1:0]  GD_LAST  = GD_W'(GOOD_WINDOWS - 1);
  localparam logic [BD_W-1:0]  BD_LAST  = BD_W'(BAD_WINDOWS - 1);
  localparam logic [CNT_W-1:0] CMIN     = CNT_W'(CNT_MIN);
  localparam logic [CNT_W-1:0] CMAX     = CNT_W'(CNT_MAX);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               sync1_r;
  logic               sync2_r;
  logic               sync3_r;
  logic               edge_s;
  logic [PW_W-1:0]    pwr_tmr_r;
  logic [WIN_W-1:0]   win_tmr_r;
  logic [CNT_W-1:0]   edge_cnt_r;
  logic [CNT_W-1:0]   cnt_fin_s;
  logic [GD_W-1:0]    good_cnt_r;
  logic [BD_W-1:0]    bad_cnt_r;
  logic [CNT_W-1:0]   meas_r;
  logic               pwdnb_r;
  logic               ok_r;
  logic               fault_r;
  logic               go_pwrup_s;
  logic               publish_s;
  logic               win_end_s;
  logic               in_range_s;
  logic               clr_s;
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
  localparam int RT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RETRY_CYCLES - 1);
  logic [RT_W-1:0]    retry_tmr_r;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic inc);
    logic [CNT_W-1:0] res;
    if (inc && (val != {CNT_W{1'b1}})) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

  assign edge_s     = sync2_r ^ sync3_r;
  assign cnt_fin_s  = sat_inc(edge_cnt_r, edge_s);
  assign in_range_s = (cnt_fin_s >= CMIN) && (cnt_fin_s <= CMAX);
  assign win_end_s  = ((state_r == ST_MEASURE) || (state_r == ST_LOCKED)) && (win_tmr_r == WIN_LAST);
  assign clr_s      = (state_nxt_s != state_r) || go_pwrup_s;

  // Two-flop synchroniser plus one flop of history for toggle edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= refclk_tgl;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next-state decode: enable drop beats restart, restart beats a window result
  always_comb begin
    state_nxt_s = state_r;
    go_pwrup_s  = 1'b0;
    publish_s   = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_OFF;
    end else if (restart && (state_r != ST_OFF)) begin
      state_nxt_s = ST_PWRUP;
      go_pwrup_s  = 1'b1;
    end else begin
      case (state_r)
        ST_OFF: begin
          state_nxt_s = ST_PWRUP;
        end
        ST_PWRUP: begin
          if (pwr_tmr_r == PW_LAST) begin
            state_nxt_s = ST_MEASURE;
          end else begin
            state_nxt_s = ST_PWRUP;
          end
        end
        ST_MEASURE: begin
          publish_s = win_end_s;
          if (win_end_s && in_range_s && (good_cnt_r == GD_LAST)) begin
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          publish_s = win_end_s;
          if (win_end_s && !in_range_s && (bad_cnt_r == BD_LAST)) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        ST_FAULT: begin
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
          if (retry_tmr_r == RT_LAST) begin
            state_nxt_s = ST_PWRUP;
            go_pwrup_s  = 1'b1;
          end else begin
            state_nxt_s = ST_FAULT;
          end
`else
          state_nxt_s = ST_FAULT;
`endif
        end
        default: begin
          state_nxt_s = ST_OFF;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Timers and window counters; any state change or restart re-arms them from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_tmr_r   <= {PW_W{1'b0}};
      win_tmr_r   <= {WIN_W{1'b0}};
      edge_cnt_r  <= {CNT_W{1'b0}};
      good_cnt_r  <= {GD_W{1'b0}};
      bad_cnt_r   <= {BD_W{1'b0}};
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
      retry_tmr_r <= {RT_W{1'b0}};
`endif
    end else if (clr_s) begin
      pwr_tmr_r   <= {PW_W{1'b0}};
      win_tmr_r   <= {WIN_W{1'b0}};
      edge_cnt_r  <= {CNT_W{1'b0}};
      good_cnt_r  <= {GD_W{1'b0}};
      bad_cnt_r   <= {BD_W{1'b0}};
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
      retry_tmr_r <= {RT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_PWRUP: begin
          pwr_tmr_r <= pwr_tmr_r + PW_W'(1);
        end
        ST_MEASURE, ST_LOCKED: begin
          if (win_end_s) begin
            win_tmr_r  <= {WIN_W{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            if (state_r == ST_MEASURE) begin
              good_cnt_r <= in_range_s ? (good_cnt_r + GD_W'(1)) : {GD_W{1'b0}};
            end else begin
              bad_cnt_r  <= in_range_s ? {BD_W{1'b0}} : (bad_cnt_r + BD_W'(1));
            end
          end else begin
            win_tmr_r  <= win_tmr_r + WIN_W'(1);
            edge_cnt_r <= cnt_fin_s;
          end
        end
        ST_FAULT: begin
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
          retry_tmr_r <= retry_tmr_r + RT_W'(1);
`endif
        end
        default: begin
          pwr_tmr_r <= pwr_tmr_r;
        end
      endcase
    end
  end

  // Registered outputs decoded from the next state; a restart entry drops pwdnb for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwdnb_r <= 1'b0;
      ok_r    <= 1'b0;
      fault_r <= 1'b0;
      meas_r  <= {CNT_W{1'b0}};
    end else begin
      pwdnb_r <= (state_nxt_s != ST_OFF) && !go_pwrup_s;
      ok_r    <= (state_nxt_s == ST_LOCKED);
      fault_r <= (state_nxt_s == ST_FAULT);
      if (publish_s) begin
        meas_r <= cnt_fin_s;
      end
    end
  end

  assign refclk_pwdnb = pwdnb_r;
  assign refclk_ok    = ok_r;
  assign fault        = fault_r;
  assign meas_count   = meas_r;
  assign state_o      = state_r;

endmodule

// File: tb/tb_refclk_sequencer.sv
// Randomized self-checking bench for refclk_sequencer against a window-level behavioural model.
module tb_refclk_sequencer;

  localparam int PWRUP = 16;
  localparam int WIN   = 64;
  localparam int CMIN  = 14;
  localparam int CMAX  = 18;
  localparam int GOOD  = 2;
  localparam int BAD   = 2;
  localparam int S_OFF = 0, S_PWR = 1, S_MEAS = 2, S_LOCK = 3, S_FAULT = 4;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        restart;
  logic        tgl;
  logic        refclk_pwdnb;
  logic        refclk_ok;
  logic        fault;
  logic [15:0] meas_count;
  logic [2:0]  state_o;

  int errors = 0;
  int checks = 0;
  int mdl_state = S_OFF;
  int mdl_run   = 0;
  int mdl_meas  = 0;

  refclk_sequencer #(
    .PWRUP_CYCLES (PWRUP),
    .WINDOW_CYCLES(WIN),
    .CNT_W        (16),
    .CNT_MIN      (CMIN),
    .CNT_MAX      (CMAX),
    .GOOD_WINDOWS (GOOD),
    .BAD_WINDOWS  (BAD)
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
    ,
    .RETRY_CYCLES (32)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .restart     (restart),
    .refclk_tgl  (tgl),
    .refclk_pwdnb(refclk_pwdnb),
    .refclk_ok   (refclk_ok),
    .fault       (fault),
    .meas_count  (meas_count),
    .state_o     (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {state, pwdnb, ok, fault} for a settled (non-pulsed) state
  function automatic logic [5:0] exp_stat(input int st);
    return {3'(st), (st != S_OFF), (st == S_LOCK), (st == S_FAULT)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered PWRUP; ends one cycle into MEASURE
  task automatic check_pwrup(input bit dropped, input string tag);
    logic [5:0] obs;
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== {3'd1, !dropped, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL %s pwrup_entry: got %b expected %b", tag, obs, {3'd1, !dropped, 1'b0, 1'b0});
    end
    for (int k = 1; k < PWRUP; k++) begin
      cycle();
      if (k == 1) begin
        checks++;
        if (refclk_pwdnb !== 1'b1) begin
          errors++;
          $display("FAIL %s pwdnb_second_cycle: got %b expected 1", tag, refclk_pwdnb);
        end
      end
    end
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL %s pwrup_last: got %0d expected 1", tag, state_o);
    end
    cycle();
    mdl_state = S_MEAS;
    mdl_run   = 0;
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== exp_stat(S_MEAS)) begin
      errors++;
      $display("FAIL %s measure_entry: got %b expected %b", tag, obs, exp_stat(S_MEAS));
    end
  endtask

  task automatic enable_from_off(input bit with_restart, input string tag);
    enable  = 1'b1;
    restart = with_restart;
    cycle();
    restart = 1'b0;
    check_pwrup(1'b0, tag);
  endtask

  task automatic do_restart(input string tag);
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    check_pwrup(1'b1, tag);
  endtask

  task automatic go_off(input string tag);
    logic [5:0] obs;
    enable = 1'b0;
    cycle();
    mdl_state = S_OFF;
    mdl_run   = 0;
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== exp_stat(S_OFF) || meas_count !== 16'(mdl_meas)) begin
      errors++;
      $display("FAIL %s go_off: got %b/%0d expected %b/%0d", tag, obs, meas_count, exp_stat(S_OFF), mdl_meas);
    end
  endtask

  // One full window with n evenly spaced refclk edges, then model update and checks
  task automatic run_window(input int n, input string tag);
    logic [5:0] obs;
    bit inr;
    for (int c = 0; c < WIN; c++) begin
      if (c >= 4 && c < 4 + 2 * n && ((c - 4) % 2) == 0) tgl = ~tgl;
      if (c == WIN - 1) begin
        obs = {state_o, refclk_pwdnb, refclk_ok, fault};
        checks++;
        if (obs !== exp_stat(mdl_state)) begin
          errors++;
          $display("FAIL %s pre_window_end: got %b expected %b", tag, obs, exp_stat(mdl_state));
        end
      end
      cycle();
    end
    mdl_meas = n;
    inr = (n >= CMIN) && (n <= CMAX);
    if (mdl_state == S_MEAS) begin
      mdl_run = inr ? mdl_run + 1 : 0;
      if (mdl_run == GOOD) begin mdl_state = S_LOCK; mdl_run = 0; end
    end else begin
      mdl_run = inr ? 0 : mdl_run + 1;
      if (mdl_run == BAD) begin mdl_state = S_FAULT; mdl_run = 0; end
    end
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== exp_stat(mdl_state)) begin
      errors++;
      $display("FAIL %s window_status: got %b expected %b", tag, obs, exp_stat(mdl_state));
    end
    checks++;
    if (meas_count !== 16'(mdl_meas)) begin
      errors++;
      $display("FAIL %s meas_count: got %0d expected %0d", tag, meas_count, mdl_meas);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; restart = 1'b0; tgl = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({state_o, refclk_pwdnb, refclk_ok, fault, meas_count} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%0d expected all zero", {state_o, refclk_pwdnb, refclk_ok, fault}, meas_count);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle: got %0d expected 0", state_o);
    end
  endtask

  task automatic test_nominal();
    enable_from_off(1'b0, "nominal");
    run_window(16, "nominal");
    run_window(16, "nominal");
    checks++;
    if (refclk_ok !== 1'b1 || meas_count !== 16'd16 || state_o !== 3'd3) begin
      errors++;
      $display("FAIL nominal_lock: got ok=%b meas=%0d st=%0d expected ok=1 meas=16 st=3", refclk_ok, meas_count, state_o);
    end
    go_off("nominal");
  endtask

  task automatic test_dead_clock();
    enable_from_off(1'b0, "dead");
    for (int w = 0; w < 3; w++) run_window(0, "dead");
    checks++;
    if (meas_count !== 16'd0 || refclk_ok !== 1'b0 || fault !== 1'b0 || state_o !== 3'd2) begin
      errors++;
      $display("FAIL dead_clock: got meas=%0d ok=%b fault=%b st=%0d expected 0/0/0/2", meas_count, refclk_ok, fault, state_o);
    end
    go_off("dead");
  endtask

  task automatic test_loss_and_fault_exit();
    logic [5:0] obs;
    enable_from_off(1'b0, "loss");
    run_window(16, "loss");
    run_window(16, "loss");
    run_window(0, "loss");
    run_window(0, "loss");
    checks++;
    if (state_o !== 3'd4 || fault !== 1'b1 || refclk_ok !== 1'b0) begin
      errors++;
      $display("FAIL loss_fault: got st=%0d fault=%b ok=%b expected 4/1/0", state_o, fault, refclk_ok);
    end
`ifdef REFCLK_SEQ_AUTO_RETRY_EN
    repeat (31) cycle();
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== exp_stat(S_FAULT)) begin
      errors++;
      $display("FAIL retry_wait: got %b expected %b", obs, exp_stat(S_FAULT));
    end
    cycle();
    check_pwrup(1'b1, "auto_retry");
`else
    repeat (40) cycle();
    obs = {state_o, refclk_pwdnb, refclk_ok, fault};
    checks++;
    if (obs !== exp_stat(S_FAULT)) begin
      errors++;
      $display("FAIL fault_sticky: got %b expected %b", obs, exp_stat(S_FAULT));
    end
    do_restart("loss_restart");
`endif
    run_window(16, "relock");
    run_window(16, "relock");
    go_off("loss");
  endtask

  task automatic test_range_recovery();
    enable_from_off(1'b0, "range");
    run_window(16, "range");
    run_window(16, "range");
    run_window(20, "range");
    run_window(16, "range");
    run_window(20, "range");
    run_window(16, "range");
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL range_stays_locked: got %0d expected 3", state_o);
    end
    run_window(12, "range");
    run_window(12, "range");
    do_restart("range_restart");
    go_off("range");
  endtask

  task automatic test_random();
    int n;
    int pick;
    for (int it = 0; it < 6; it++) begin
      enable_from_off(1'($urandom_range(0, 1)), "random");
      for (int w = 0; w < 12 && mdl_state != S_FAULT; w++) begin
        pick = $urandom_range(0, 3);
        if (pick == 1) n = $urandom_range(0, CMIN - 1);
        else if (pick == 2) n = $urandom_range(CMAX + 1, 24);
        else n = $urandom_range(CMIN, CMAX);
        run_window(n, "random");
      end
      if (mdl_state == S_FAULT) do_restart("random_restart");
      go_off("random");
    end
  endtask

  task automatic test_enable_drop();
    enable_from_off(1'b0, "drop");
    run_window(17, "drop");
    for (int c = 0; c < 20; c++) begin
      if (c >= 4 && (c % 2) == 0) tgl = ~tgl;
      cycle();
    end
    enable = 1'b0;
    restart = 1'b1;
    cycle();
    restart = 1'b0;
    mdl_state = S_OFF;
    checks++;
    if ({state_o, refclk_pwdnb, refclk_ok, fault} !== 6'd0 || meas_count !== 16'd17) begin
      errors++;
      $display("FAIL enable_drop: got %b/%0d expected 000000/17", {state_o, refclk_pwdnb, refclk_ok, fault}, meas_count);
    end
    repeat (5) cycle();
    checks++;
    if (state_o !== 3'd0 || meas_count !== 16'd17) begin
      errors++;
      $display("FAIL enable_drop_hold: got %0d/%0d expected 0/17", state_o, meas_count);
    end
  endtask

  task automatic test_async_reset();
    enable_from_off(1'b0, "arst");
    run_window(16, "arst");
    run_window(16, "arst");
    repeat (10) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state_o, refclk_pwdnb, refclk_ok, fault, meas_count} !== 22'd0) begin
      errors++;
      $display("FAIL async_reset: got %b/%0d expected all zero", {state_o, refclk_pwdnb, refclk_ok, fault}, meas_count);
    end
    enable = 1'b0;
    cycle();
    rst_n = 1'b1;
    mdl_state = S_OFF;
    mdl_meas  = 0;
    cycle();
    checks++;
    if (state_o !== 3'd0 || meas_count !== 16'd0) begin
      errors++;
      $display("FAIL after_reset: got %0d/%0d expected 0/0", state_o, meas_count);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_dead_clock();
    test_loss_and_fault_exit();
    test_range_recovery();
    test_random();
    test_enable_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
